// File: rtl/arm_pkg.sv
// Shared ARM-style constants: condition codes, ALU encodings, flag indices.
// Used by the condition-evaluation and flag-update logic.
package arm_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condcheck.sv
// Evaluates a 4-bit condition field against {N,Z,C,V}.
// NV always evaluates false so no X can leak out.
module condcheck
    import arm_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_condex = 1'b0;
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = w_ge;
            COND_LT: o_condex = ~w_ge;
            COND_GT: o_condex = ~w_z & w_ge;
            COND_LE: o_condex = w_z | ~w_ge;
            COND_AL: o_condex = 1'b1;
            default: o_condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Flag register, condition latch and gated write enables.
// Optional flag shadow (Snapshot/Restore) under CONDLOGIC_FLAG_SNAPSHOT_EN.
module condlogic
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [1:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [31:0] ALUResult,
    input  logic [1:0]  FlagW,
    input  logic        CondCapture,
    input  logic        PCS,
    input  logic        NextPC,
    input  logic        RegW,
    input  logic        MemW,
`ifdef CONDLOGIC_FLAG_SNAPSHOT_EN
    input  logic        Snapshot,
    input  logic        Restore,
`endif
    output logic [3:0]  Flags,
    output logic        CondExReg,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite
);

    logic [3:0]  r_flags;
    logic        r_condex;
    logic        w_sub;
    logic [31:0] w_bp;
    logic [32:0] w_sum;
    logic [3:0]  w_nflags;
    logic        w_cond_ok;
    logic        w_wr_nz;
    logic        w_wr_cv;

    condcheck u_condcheck (
        .i_cond   (Cond),
        .i_flags  (r_flags),
        .o_condex (w_cond_ok)
    );

    // Carry/overflow come from the adder path, recomputed from the operands
    assign w_sub = (ALUControl == ALU_SUB);
    assign w_bp  = w_sub ? ~SrcB : SrcB;
    assign w_sum = {1'b0, SrcA} + {1'b0, w_bp} + {32'd0, w_sub};

    assign w_nflags[FLAG_N] = ALUResult[31];
    assign w_nflags[FLAG_Z] = (ALUResult == 32'd0);
    assign w_nflags[FLAG_C] = w_sum[32];
    assign w_nflags[FLAG_V] = (SrcA[31] == w_bp[31]) & (w_sum[31] != SrcA[31]);

    assign w_wr_nz = FlagW[FLAGW_NZ] & r_condex;
    assign w_wr_cv = FlagW[FLAGW_CV] & r_condex & ~ALUControl[1];

`ifdef CONDLOGIC_FLAG_SNAPSHOT_EN
    logic [3:0] r_shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= 4'b0000;
        end else if (Snapshot) begin
            r_shadow <= r_flags;
        end
    end

    // Restore wins over FlagW and bypasses the condition gate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (Restore) begin
            r_flags <= r_shadow;
        end else begin
            if (w_wr_nz) begin
                r_flags[FLAG_N] <= w_nflags[FLAG_N];
                r_flags[FLAG_Z] <= w_nflags[FLAG_Z];
            end
            if (w_wr_cv) begin
                r_flags[FLAG_C] <= w_nflags[FLAG_C];
                r_flags[FLAG_V] <= w_nflags[FLAG_V];
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_wr_nz) begin
                r_flags[FLAG_N] <= w_nflags[FLAG_N];
                r_flags[FLAG_Z] <= w_nflags[FLAG_Z];
            end
            if (w_wr_cv) begin
                r_flags[FLAG_C] <= w_nflags[FLAG_C];
                r_flags[FLAG_V] <= w_nflags[FLAG_V];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_condex <= 1'b0;
        end else if (CondCapture) begin
            r_condex <= w_cond_ok;
        end
    end

    assign Flags     = r_flags;
    assign CondExReg = r_condex;
    assign PCWrite   = (PCS & r_condex) | NextPC;
    assign RegWrite  = RegW & r_condex;
    assign MemWrite  = MemW & r_condex;

endmodule

// File: doc/condlogic.md
CONDLOGIC -- requirements
Module: condlogic

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: Cond  input  4  instruction condition field.
REQ-004 SHALL: ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-005 SHALL: SrcA, SrcB  input  32 each  ALU operands.
REQ-006 SHALL: ALUResult  input  32  ALU result for the same operation.
REQ-007 SHALL: FlagW  input  2  [1] write N,Z; [0] write C,V.
REQ-008 SHALL: CondCapture  input  1  latch condition outcome (decode state).
REQ-009 SHALL: PCS, NextPC, RegW, MemW  input  1 each  ungated control requests.
REQ-010 SHALL: Flags  output  4  registered {N,Z,C,V}.
REQ-011 SHALL: CondExReg  output  1  latched condition outcome.
REQ-012 SHALL: PCWrite, RegWrite, MemWrite  output  1 each  gated write enables.

Function
REQ-013 SHALL compute next flag values combinationally:
- N = ALUResult[31].
- Z = (ALUResult == 0).
- For ADD/SUB: {C,sum} = SrcA + (SUB ? ~SrcB : SrcB) + SUB as a 33-bit sum.
- V = (SrcA[31] == B'[31]) & (sum[31] != SrcA[31]), where B' is the adjusted SrcB.
REQ-014 SHALL write C,V only when FlagW[0] & CondExReg & ~ALUControl[1]; logical ops SHALL never modify C,V.
REQ-015 SHALL write N,Z when FlagW[1] & CondExReg; the update is visible on Flags the cycle after the edge.
REQ-016 SHALL evaluate the condition of Cond against the current Flags register, not the next-flag values.
REQ-017 SHALL force the evaluated condition to 0 when Cond = 4'b1111 (no X propagation).
REQ-018 SHALL load CondExReg with the evaluated condition on an edge where CondCapture = 1, and hold it otherwise.
REQ-019 SHALL drive the write enables combinationally:
- PCWrite = (PCS & CondExReg) | NextPC.
- RegWrite = RegW & CondExReg.
- MemWrite = MemW & CondExReg.
REQ-020 SHALL gate flag writes with the pre-edge CondExReg when CondCapture and FlagW are asserted in the same cycle.
REQ-021 SHALL give no write enable more than 0 cycles of latency from its request input.

Reset
REQ-022 SHALL, while reset = 0, force Flags = 4'b0000 and CondExReg = 0 immediately, regardless of clk.
REQ-023 SHALL, during reset, give PCWrite = NextPC and RegWrite = MemWrite = 0.
REQ-024 SHALL discard any in-progress capture or flag write when reset is asserted mid-operation.

Configuration
REQ-025 SHALL support macro CONDLOGIC_FLAG_SNAPSHOT_EN.
- When defined, it adds inputs Snapshot (1) and Restore (1) and a 4-bit shadow register, which resets to 0.
- Snapshot copies Flags into the shadow.
- Restore loads Flags from the shadow, ungated by CondExReg, and has priority over FlagW writes.
- Snapshot and Restore in the same cycle swap Flags and the shadow.
REQ-026 SHALL, when CONDLOGIC_FLAG_SNAPSHOT_EN is undefined, omit those ports and the shadow register; Flags change only via FlagW.

Structure
REQ-027 SHALL take condition-code constants (EQ..AL, NV = 4'b1111), ALUControl encodings and flag bit indices from the shared package arm_pkg.
REQ-028 SHALL instantiate the existing condcheck module as its single sub-module for condition evaluation.

Verification
REQ-029 SHALL cover SUB with SrcA = 5, SrcB = 5, FlagW = 11, CondExReg = 1 -> next cycle Flags = 0110 (Z=1, C=1).
REQ-030 SHALL cover ADD with SrcA = 0x7FFFFFFF, SrcB = 1, FlagW = 11 -> Flags = 1001 (N=1, V=1).
REQ-031 SHALL cover Flags = 0100, Cond = 0001 (NE), CondCapture = 1 -> CondExReg = 0; then RegW = MemW = PCS = 1 -> all gated enables 0, FlagW = 11 leaves Flags = 0100.
REQ-032 SHALL cover ORR with Flags = 0011, FlagW = 11, result 0x80000000 -> Flags = 1011 (C,V preserved).
REQ-033 SHALL cover Cond = 1111 with CondCapture = 1 -> CondExReg = 0; NextPC = 1 -> PCWrite = 1.
REQ-034 SHALL cover reset pulsed low mid-cycle after Flags = 1111 -> Flags = 0000 and CondExReg = 0 immediately; with the macro defined, Snapshot then Restore round-trips 1010.
